// File: rtl/mem_access_arbiter.sv
// Memory access sequencer/arbiter: shares one MAR/memory port between IF and DS.
// Ports: clk, clr_n (async low); IF/DS request side; MAR/MDR/memory strobes; acks, busy, owner.
module mem_access_arbiter #(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 9
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        ds_req,
    input  logic        ds_we,
    input  logic [31:0] ds_addr,
    input  logic [31:0] ds_wdata,
    output logic        mar_en,
    output logic [31:0] mar_d,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    output logic        mdr_en,
    output logic        if_ack,
    output logic        ds_ack,
    output logic        busy,
    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACCESS,
        ACK
    } state_t;

    localparam logic [3:0]  CNT_LAST  = 4'(MEM_LAT - 1);
    localparam logic [31:0] ADDR_MASK = 32'((64'd1 << ADDR_W) - 64'd1);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic        own_q, own_nx;
    logic        last_q, last_nx;
    logic        we_q, we_nx;
    logic [31:0] addr_q, addr_nx;
    logic [31:0] wdata_q, wdata_nx;
    logic        grant_ds;

    // last_q resets to DS so that IF wins the first contested grant.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            own_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            own_q   <= own_nx;
            last_q  <= last_nx;
            we_q    <= we_nx;
            addr_q  <= addr_nx;
            wdata_q <= wdata_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        own_nx    = own_q;
        last_nx   = last_q;
        we_nx     = we_q;
        addr_nx   = addr_q;
        wdata_nx  = wdata_q;
        grant_ds  = 1'b0;
        mar_en    = 1'b0;
        mar_d     = 32'd0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = 32'd0;
        mdr_en    = 1'b0;
        if_ack    = 1'b0;
        ds_ack    = 1'b0;

        unique case (state)
            IDLE: begin
                if (if_req || ds_req) begin
                    // Contested: give it to whoever did not own the last one.
                    grant_ds = ds_req && (!if_req || !last_q);
                    own_nx   = grant_ds;
                    addr_nx  = grant_ds ? ds_addr : if_addr;
                    we_nx    = grant_ds && ds_we;
                    wdata_nx = grant_ds ? ds_wdata : 32'd0;
                    cnt_nx   = 4'd0;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                mar_en   = 1'b1;
                mar_d    = addr_q & ADDR_MASK;
                cnt_nx   = 4'd0;
                state_nx = ACCESS;
            end
            ACCESS: begin
                mem_rd    = !we_q;
                mem_wr    = we_q;
                mem_wdata = we_q ? wdata_q : 32'd0;
                mdr_en    = !we_q && (cnt == CNT_LAST);
                if (cnt == CNT_LAST) begin
                    cnt_nx   = 4'd0;
                    state_nx = ACK;
                end else begin
                    cnt_nx = cnt + 4'd1;
                end
            end
            ACK: begin
                if_ack   = !own_q;
                ds_ack   = own_q;
                last_nx  = own_q;
                cnt_nx   = 4'd0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign busy  = (state != IDLE);
    assign owner = own_q;

endmodule
